ninja_game_sequencer: RTL and testbench
=======================================

# ninja_game_sequencer

Central sequencer for the ninja/elevator/shuriken game datapath. It divides `clk_input` into a base game tick and issues one-cycle step enables to the elevator, shuriken and ninja movement logic. It runs the game state machine (idle, run, pause, respawn, game over) and owns the lives and level counters. It also issues the respawn pulse that reloads all object positions.

## Interface

Parameters:
- `TICK_DIV`, default 8: `clk_input` cycles per base tick; must be ≥2.
- `ELEV_PERIOD`, default 2: base ticks per elevator step; must be ≥1.
- `SHUR_PERIOD`, default 4: base ticks per shuriken step at level 0; must be ≥1.
- `RESPAWN_TICKS`, default 3: base ticks frozen after a respawn pulse; must be ≥1.
- `MAX_LEVEL`, default 3: highest level number, 0..7.

Ports:
- `clk_input` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: level input; its rising edge starts or restarts a game.
- `pause` in 1: level input; held high freezes the game.
- `hit` in 1: collision flag (touch or drop), sampled each cycle.
- `goal` in 1: level-cleared flag, sampled each cycle.
- `state` out 3: current FSM state encoding.
- `lives` out 2: retries remaining.
- `level` out 3: current level.
- `tick` out 1: one-cycle base-tick pulse.
- `elev_step` out 1: one-cycle elevator advance.
- `shur_step` out 1: one-cycle shuriken advance.
- `ninja_en` out 1: ninja movement allowed, level signal.
- `respawn` out 1: one-cycle reload of all positions.
- `game_over` out 1: high in OVER.
- `win` out 1: high in OVER when reached by clearing MAX_LEVEL.

## Operation

- **States and encodings:** IDLE=0, RUN=1, PAUSE=2, RESPAWN=3, OVER=4. All outputs are registered.
- **Reset values:** state=IDLE, lives=2, level=0, tick/elev_step/shur_step/ninja_en/respawn/game_over/win=0, all counters=0.
- **Start edge:** `start_rise = start & ~start_q`, where `start_q` is `start` delayed one cycle (reset value 0).
- **IDLE:** lives←2, level←0, win←0. On `start_rise` → RESPAWN.
- **RESPAWN:**
  - `respawn`=1 in the first cycle only.
  - Tick divider and respawn counter start from 0.
  - After RESPAWN_TICKS ticks → RUN; the transition happens on the cycle `tick` pulses for the last time.
  - `hit` and `goal` are ignored in this state.
- **RUN:**
  - `ninja_en`=1.
  - `hit`:
    - lives>0: lives←lives−1, → RESPAWN.
    - lives==0: → OVER, win←0.
  - `goal` without `hit`:
    - level<MAX_LEVEL: level←level+1, → RESPAWN.
    - level==MAX_LEVEL: → OVER, win←1.
  - `hit` and `goal` in the same cycle: `hit` wins and `goal` is discarded.
  - `pause`=1 with no `hit` or `goal` → PAUSE (only when SEQ_PAUSE_EN is defined).
- **PAUSE:**
  - Divider and step counters hold their values.
  - No `tick`, no steps, `ninja_en`=0.
  - `hit` and `goal` are ignored.
  - `pause`=0 → RUN, resuming the count where it stopped.
- **OVER:** `game_over`=1. `win` and `level` hold. On `start_rise` → IDLE.
- **Reset mid-operation:** returns to the reset values immediately; no `respawn` pulse is issued.

## Timing

- **Base tick:**
  - `tick_cnt` counts 0..TICK_DIV−1 in RUN and RESPAWN only.
  - `tick`=1 in the cycle `tick_cnt`==TICK_DIV−1, after which the count wraps to 0.
  - `tick_cnt` clears on entry to RESPAWN.
- **Elevator steps:**
  - `elev_cnt` increments on each `tick` in RUN and wraps at ELEV_PERIOD−1.
  - `elev_step`=1 on the `tick` cycle where `elev_cnt`==ELEV_PERIOD−1.
- **Shuriken steps:**
  - Effective period `sp` = max(1, SHUR_PERIOD−level), computed in 4-bit unsigned with a saturating subtract.
  - `shur_cnt` increments on each `tick` in RUN; `shur_step`=1 on the `tick` cycle where `shur_cnt`≥`sp`−1, and `shur_cnt` then clears.
  - Because the compare is ≥, a level change can never strand the counter above `sp`.
- **Counter clearing:** `elev_cnt` and `shur_cnt` clear on entry to RESPAWN.
- **Step gating:** steps never assert outside RUN, including on the RESPAWN→RUN transition tick.
- **Latency:** a `hit` sampled at edge N gives state=RESPAWN and `respawn`=1 after edge N, i.e. one cycle of latency. `lives` updates on the same edge.

## Configuration

- **`SEQ_PAUSE_EN` defined:** the `pause` input and PAUSE state are implemented as described above.
- **Not defined:**
  - `pause` is ignored and PAUSE is unreachable.
  - The state encoding is unchanged, and `state` never equals 2.

## Structure

- Shared package `ninja_seq_pkg`:
  - State enum `seq_state_t` with the encodings above.
  - `LIVES_INIT`=2.
  - Width constants `LIVES_W`=2, `LEVEL_W`=3.
- Sub-module `game_tick_divider` holds the tick counter with `run` and `clear` inputs and drives the `tick` output.
- FSM and counters stay in `ninja_game_sequencer`.

## Test plan

All scenarios use TICK_DIV=4, ELEV_PERIOD=2, SHUR_PERIOD=3, RESPAWN_TICKS=2, MAX_LEVEL=1.

- **Start:** reset, then `start` rises. Required: `respawn` for 1 cycle; RUN 8 cycles later; in RUN, `elev_step` every 8 cycles and `shur_step` every 12 cycles.
- **Hit and retries:** `hit` pulse in RUN. Required: lives 2→1 and RESPAWN. Two more hits, each after RUN resumes: lives 1→0, then OVER with `game_over`=1 and `win`=0.
- **Goal and win:** `goal` at level 0. Required: level=1, RESPAWN, and `shur_step` every 8 cycles (`sp`=2). A second `goal` then gives OVER with `win`=1.
- **Simultaneous events:** `hit` and `goal` in the same cycle. Required: level unchanged and lives decremented.
- **Pause (SEQ_PAUSE_EN defined):** `pause` held for 20 cycles mid-count. Required: no steps while paused, and the next `elev_step` arrives exactly the remaining cycles after release. Without the macro, `state` never equals 2.
- **Reset mid-operation:** `reset` during RESPAWN. Required: IDLE immediately, lives=2, `respawn`=0, and no steps issued.

Source files
------------

// File: rtl/ninja_seq_pkg.sv
// ninja_seq_pkg: shared state encoding, widths and shuriken period helper for the game sequencer
package ninja_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PAUSE   = 3'd2,
    S_RESPAWN = 3'd3,
    S_OVER    = 3'd4
  } seq_state_t;
  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 3;
  localparam logic [LIVES_W-1:0] LIVES_INIT = 2'd2;
  // Shuriken period shrinks with level but never below one tick.
  function automatic logic [3:0] shur_period_eff(input logic [3:0] base, input logic [LEVEL_W-1:0] lvl);
    logic [3:0] d;
    d = base > {1'b0, lvl} ? base - {1'b0, lvl} : 4'd0;
    return d == 4'd0 ? 4'd1 : d;
  endfunction
endpackage

// File: rtl/game_tick_divider.sv
// game_tick_divider: divides clk_input into a one-cycle base tick while run is high
module game_tick_divider #(
  parameter int TICK_DIV = 8
) (
  input  logic clk_input,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_input or posedge reset)
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run) cnt <= cnt == LAST ? '0 : cnt + W'(1);
  assign tick = run & (cnt == LAST);
endmodule

// File: rtl/ninja_game_sequencer.sv
// ninja_game_sequencer: game FSM, lives/level counters and step enables for the game datapath
// Optional PAUSE state is built only when SEQ_PAUSE_EN is defined.
module ninja_game_sequencer
  import ninja_seq_pkg::*;
#(
  parameter int TICK_DIV      = 8,
  parameter int ELEV_PERIOD   = 2,
  parameter int SHUR_PERIOD   = 4,
  parameter int RESPAWN_TICKS = 3,
  parameter int MAX_LEVEL     = 3
) (
  input  logic               clk_input,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               hit,
  input  logic               goal,
  output logic [2:0]         state,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               elev_step,
  output logic               shur_step,
  output logic               ninja_en,
  output logic               respawn,
  output logic               game_over,
  output logic               win
);
  localparam int EW = ELEV_PERIOD > 1 ? $clog2(ELEV_PERIOD) : 1;
  localparam int RW = RESPAWN_TICKS > 1 ? $clog2(RESPAWN_TICKS) : 1;
  localparam logic [EW-1:0] ELEV_LAST = EW'(ELEV_PERIOD - 1);
  localparam logic [RW-1:0] RSP_LAST = RW'(RESPAWN_TICKS - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);
  localparam logic [3:0] SHUR_BASE = 4'(SHUR_PERIOD);
  seq_state_t st_q, st_n;
  logic start_q, start_rise, in_run, active, enter_rsp, tick_i, win_n;
  logic [LIVES_W-1:0] lives_n;
  logic [LEVEL_W-1:0] level_n;
  logic [EW-1:0] elev_cnt;
  logic [3:0] shur_cnt, sp_last;
  logic [RW-1:0] rsp_cnt;
`ifndef SEQ_PAUSE_EN
  logic pause_unused;
  assign pause_unused = pause;
`endif
  assign start_rise = start & ~start_q;
  assign in_run = st_q == S_RUN;
  assign active = in_run | (st_q == S_RESPAWN);
  assign enter_rsp = (st_n == S_RESPAWN) && (st_q != S_RESPAWN);
  assign sp_last = shur_period_eff(SHUR_BASE, level) - 4'd1;
  game_tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk_input(clk_input),
    .reset(reset),
    .run(active),
    .clear(enter_rsp),
    .tick(tick_i)
  );
  always_comb begin
    st_n = st_q;
    lives_n = lives;
    level_n = level;
    win_n = win;
    case (st_q)
      S_IDLE: begin
        lives_n = LIVES_INIT;
        level_n = '0;
        win_n = 1'b0;
        if (start_rise) st_n = S_RESPAWN;
      end
      S_RESPAWN: if (tick_i && rsp_cnt == RSP_LAST) st_n = S_RUN;
      S_RUN:
        if (hit) begin
          if (lives != '0) begin
            lives_n = lives - 2'd1;
            st_n = S_RESPAWN;
          end else begin
            win_n = 1'b0;
            st_n = S_OVER;
          end
        end else if (goal) begin
          if (level < LEVEL_MAX) begin
            level_n = level + 3'd1;
            st_n = S_RESPAWN;
          end else begin
            win_n = 1'b1;
            st_n = S_OVER;
          end
        end
`ifdef SEQ_PAUSE_EN
        else if (pause) st_n = S_PAUSE;
      S_PAUSE: if (!pause) st_n = S_RUN;
`endif
      S_OVER: if (start_rise) st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end
  // Step counters only advance on RUN ticks, so PAUSE and RESPAWN freeze them.
  always_ff @(posedge clk_input or posedge reset)
    if (reset) begin
      st_q <= S_IDLE;
      start_q <= 1'b0;
      lives <= LIVES_INIT;
      level <= '0;
      win <= 1'b0;
      respawn <= 1'b0;
      elev_cnt <= '0;
      shur_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      st_q <= st_n;
      start_q <= start;
      lives <= lives_n;
      level <= level_n;
      win <= win_n;
      respawn <= enter_rsp;
      if (enter_rsp) begin
        elev_cnt <= '0;
        shur_cnt <= '0;
        rsp_cnt <= '0;
      end else if (tick_i) begin
        if (in_run) begin
          elev_cnt <= elev_cnt == ELEV_LAST ? '0 : elev_cnt + EW'(1);
          shur_cnt <= shur_cnt >= sp_last ? 4'd0 : shur_cnt + 4'd1;
        end else rsp_cnt <= rsp_cnt + RW'(1);
      end
    end
  assign state = st_q;
  assign tick = tick_i;
  assign elev_step = tick_i & in_run & (elev_cnt == ELEV_LAST);
  assign shur_step = tick_i & in_run & (shur_cnt >= sp_last);
  assign ninja_en = in_run;
  assign game_over = st_q == S_OVER;
endmodule

// File: tb/tb_ninja_game_sequencer.sv
// tb_ninja_game_sequencer: directed plus random stimulus against an elapsed-time game model
module tb_ninja_game_sequencer;
  localparam int TD = 4, EP = 2, SP = 3, RT = 2, ML = 1;
`ifdef SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif
  logic clk_input = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, hit = 1'b0, goal = 1'b0;
  logic [2:0] state;
  logic [1:0] lives;
  logic [2:0] level;
  logic tick, elev_step, shur_step, ninja_en, respawn, game_over, win;
  int n_checks = 0, n_fail = 0;
  int m_state, m_lives, m_level, m_win, m_act, m_rt, m_respawn, m_start_q;
  always #5 clk_input = ~clk_input;
  ninja_game_sequencer #(
    .TICK_DIV(TD), .ELEV_PERIOD(EP), .SHUR_PERIOD(SP), .RESPAWN_TICKS(RT), .MAX_LEVEL(ML)
  ) dut (
    .clk_input(clk_input), .reset(reset), .start(start), .pause(pause), .hit(hit), .goal(goal),
    .state(state), .lives(lives), .level(level), .tick(tick), .elev_step(elev_step),
    .shur_step(shur_step), .ninja_en(ninja_en), .respawn(respawn), .game_over(game_over), .win(win)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // Model: m_act counts active (RUN/RESPAWN) cycles since the last respawn, m_rt the RUN ticks since then.
  function automatic int m_tick();
    return ((m_state == 1 || m_state == 3) && (m_act % TD == TD - 1)) ? 1 : 0;
  endfunction
  function automatic int sp_eff();
    return (SP - m_level < 1) ? 1 : SP - m_level;
  endfunction
  task automatic model_reset();
    m_state = 0; m_lives = 2; m_level = 0; m_win = 0;
    m_act = 0; m_rt = 0; m_respawn = 0; m_start_q = 0;
  endtask
  task automatic compare_outputs();
    int tk, r;
    tk = m_tick();
    r = (m_state == 1) ? 1 : 0;
    check("state", int'(state), m_state);
    check("lives", int'(lives), m_lives);
    check("level", int'(level), m_level);
    check("tick", int'(tick), tk);
    check("elev_step", int'(elev_step), (tk == 1 && r == 1 && m_rt % EP == EP - 1) ? 1 : 0);
    check("shur_step", int'(shur_step), (tk == 1 && r == 1 && m_rt % sp_eff() == sp_eff() - 1) ? 1 : 0);
    check("ninja_en", int'(ninja_en), r);
    check("respawn", int'(respawn), m_respawn);
    check("game_over", int'(game_over), (m_state == 4) ? 1 : 0);
    check("win", int'(win), m_win);
  endtask
  task automatic model_step(input logic st, input logic pz, input logic ht, input logic gl);
    int tk, rise, enter;
    tk = m_tick();
    rise = (st && m_start_q == 0) ? 1 : 0;
    enter = 0;
    m_start_q = st ? 1 : 0;
    case (m_state)
      0: begin
        m_lives = 2; m_level = 0; m_win = 0;
        if (rise == 1) begin m_state = 3; enter = 1; end
      end
      3: begin
        if (tk == 1 && m_act == TD * RT - 1) m_state = 1;
        m_act++;
      end
      1: begin
        m_act++;
        if (tk == 1) m_rt++;
        if (ht) begin
          if (m_lives > 0) begin m_lives--; m_state = 3; enter = 1; end
          else begin m_win = 0; m_state = 4; end
        end else if (gl) begin
          if (m_level < ML) begin m_level++; m_state = 3; enter = 1; end
          else begin m_win = 1; m_state = 4; end
        end else if (PAUSE_EN && pz) m_state = 2;
      end
      2: if (!pz) m_state = 1;
      4: if (rise == 1) m_state = 0;
      default: m_state = 0;
    endcase
    if (enter == 1) begin m_act = 0; m_rt = 0; end
    m_respawn = enter;
  endtask
  task automatic cycle(input logic st, input logic pz, input logic ht, input logic gl);
    compare_outputs();
    start = st; pause = pz; hit = ht; goal = gl;
    model_step(st, pz, ht, gl);
    @(posedge clk_input);
    @(negedge clk_input);
  endtask
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), 2);
    check("rst_respawn", int'(respawn), 0);
    check("rst_steps", int'({tick, elev_step, shur_step}), 0);
    model_reset();
    @(negedge clk_input);
    reset = 1'b0;
  endtask
  task automatic restart();
    cycle(0, 0, 0, 0); cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(1, 0, 0, 0);
  endtask
  initial begin
    logic st, pz;
    model_reset();
    repeat (2) @(negedge clk_input);
    reset = 1'b0;
    // start, then a long RUN stretch for the step cadence
    repeat (50) cycle(1, 0, 0, 0);
    // three hits: lives 2->1->0, then OVER without win
    repeat (3) begin
      cycle(1, 0, 1, 0);
      repeat (13) cycle(1, 0, 0, 0);
    end
    // goal at level 0, then at MAX_LEVEL for a win
    restart();
    repeat (12) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    repeat (40) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    repeat (5) cycle(1, 0, 0, 0);
    // simultaneous hit and goal, then reset during the following RESPAWN
    restart();
    repeat (12) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 1);
    repeat (3) cycle(1, 0, 0, 0);
    async_reset();
    repeat (4) cycle(1, 0, 0, 0);
    // pause held mid-count
    cycle(0, 0, 0, 0);
    repeat (13) cycle(1, 0, 0, 0);
    repeat (20) cycle(1, 1, 0, 0);
    repeat (30) cycle(1, 0, 0, 0);
    st = 1'b1;
    pz = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 59) == 0) st = ~st;
      if ($urandom_range(0, 39) == 0) pz = ~pz;
      cycle(st, pz, $urandom_range(0, 49) == 0, $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 799) == 0) async_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
